// File: rtl/acumulador_placar.sv
// rtl/acumulador_placar.sv - one-team score register with press synchronizer, add/subtract FSM and BCD outputs
module acumulador_placar #(
    parameter int PLACAR_MAX  = 99,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botao,
    input  logic       chavePN,
    input  logic [1:0] pontos,
    input  logic       zerar,
    output logic [6:0] placar,
    output logic [3:0] placar_dez,
    output logic [3:0] placar_uni,
    output logic       atualizado,
    output logic       bloqueado
);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        APLICA        = 2'd1,
        ESPERA_SOLTAR = 2'd2
    } estado_t;

    localparam logic [7:0] MAX8 = 8'(PLACAR_MAX);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] sync_vld;
    logic                   botao_s;
    logic                   botao_s_d;
    logic                   armado;
    logic                   borda;

    estado_t    estado;
    estado_t    estado_prox;
    logic [1:0] op_pts;
    logic       op_sub;

    logic [7:0] soma;
    logic [6:0] placar_prox;
    logic [3:0] dez_prox;
    logic [3:0] uni_prox;
    logic       atualizado_prox;
    logic       bloqueado_prox;

    assign botao_s = sync[SYNC_STAGES-1];

    // Two-flop (or deeper) synchronizer for the raw button plus its one-cycle delayed copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync      <= '0;
            botao_s_d <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], botao};
            botao_s_d <= botao_s;
        end
    end

    // Arms press detection only after a genuine released sample has crossed the synchronizer,
    // so a button still held through reset cannot masquerade as a fresh press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_vld <= '0;
            armado   <= 1'b0;
        end else begin
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            if (sync_vld[SYNC_STAGES-1] && !botao_s) begin
                armado <= 1'b1;
            end
        end
    end

    assign borda = botao_s & ~botao_s_d & armado;

    // The 8-bit sum keeps the bound check honest even at the 7-bit ceiling.
    assign soma = {1'b0, placar} + {6'b0, op_pts};

    // Next state, next score and result pulses; zerar overrides everything the FSM decided.
    always_comb begin
        estado_prox     = estado;
        placar_prox     = placar;
        atualizado_prox = 1'b0;
        bloqueado_prox  = 1'b0;
        case (estado)
            OCIOSO: begin
                if (borda) begin
                    estado_prox = (pontos == 2'd0) ? ESPERA_SOLTAR : APLICA;
                end
            end
            APLICA: begin
                estado_prox = ESPERA_SOLTAR;
                if (op_sub) begin
                    if (placar < {5'b0, op_pts}) begin
                        bloqueado_prox = 1'b1;
                    end else begin
                        placar_prox     = placar - {5'b0, op_pts};
                        atualizado_prox = 1'b1;
                    end
                end else begin
                    if (soma > MAX8) begin
                        bloqueado_prox = 1'b1;
                    end else begin
                        placar_prox     = soma[6:0];
                        atualizado_prox = 1'b1;
                    end
                end
            end
            ESPERA_SOLTAR: begin
                if (!botao_s) begin
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
        if (zerar) begin
            estado_prox     = ESPERA_SOLTAR;
            placar_prox     = 7'd0;
            atualizado_prox = 1'b0;
            bloqueado_prox  = 1'b0;
        end
    end

    // BCD digits derived from the same next-score value so they move on the same edge as placar.
    always_comb begin
        dez_prox = 4'(placar_prox / 7'd10);
        uni_prox = 4'(placar_prox % 7'd10);
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Operands are latched on the press edge so later selector changes cannot affect this press.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_pts <= 2'd0;
            op_sub <= 1'b0;
        end else if (estado == OCIOSO && borda) begin
            op_pts <= pontos;
            op_sub <= chavePN;
        end
    end

    // Score, BCD digits and the one-cycle result pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            placar     <= 7'd0;
            placar_dez <= 4'd0;
            placar_uni <= 4'd0;
            atualizado <= 1'b0;
            bloqueado  <= 1'b0;
        end else begin
            placar     <= placar_prox;
            placar_dez <= dez_prox;
            placar_uni <= uni_prox;
            atualizado <= atualizado_prox;
            bloqueado  <= bloqueado_prox;
        end
    end

endmodule

// File: tb/tb_acumulador_placar.sv
// tb/tb_acumulador_placar.sv - self-checking bench for acumulador_placar
module tb_acumulador_placar;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       botao = 1'b0;
    logic       chavePN = 1'b0;
    logic [1:0] pontos = 2'd0;
    logic       zerar = 1'b0;
    logic [6:0] placar;
    logic [3:0] placar_dez;
    logic [3:0] placar_uni;
    logic       atualizado;
    logic       bloqueado;

    int tests = 0;
    int fails = 0;

    localparam int LAT = 4;

    acumulador_placar #(.PLACAR_MAX(99), .SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .botao      (botao),
        .chavePN    (chavePN),
        .pontos     (pontos),
        .zerar      (zerar),
        .placar     (placar),
        .placar_dez (placar_dez),
        .placar_uni (placar_uni),
        .atualizado (atualizado),
        .bloqueado  (bloqueado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       sub;
        logic [1:0] pts;
        int         hold;
        int         rep;
        int         exp_placar;
        int         exp_at;
        int         exp_bl;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_score(input string nm, input int exp);
        chk({nm, "_placar"}, int'(placar), exp);
        chk({nm, "_dez"}, int'(placar_dez), exp / 10);
        chk({nm, "_uni"}, int'(placar_uni), exp % 10);
    endtask

    // One button press observed cycle by cycle; inj 1 = zerar, 2 = reset, pulsed for one cycle at inj_at.
    task automatic press(input logic sub, input logic [1:0] pts, input int hold,
                         input int inj, input int inj_at,
                         output int n_at, output int n_bl, output int first,
                         output int inv_err, output int post);
        int last;
        n_at = 0; n_bl = 0; first = 0; inv_err = 0; post = -1;
        last = ((hold > LAT) ? hold : LAT) + 6;
        @(negedge clock);
        chavePN = sub;
        pontos  = pts;
        botao   = 1'b1;
        for (int j = 1; j <= last; j++) begin
            @(negedge clock);
            if (atualizado) n_at++;
            if (bloqueado) n_bl++;
            if ((atualizado || bloqueado) && first == 0) first = j;
            if (atualizado && bloqueado) inv_err++;
            if (int'(placar) != 10 * int'(placar_dez) + int'(placar_uni)) inv_err++;
            if (inj != 0 && j == inj_at + 1)
                post = int'(placar) + int'(placar_dez) + int'(placar_uni)
                       + int'(atualizado) + int'(bloqueado);
            if (j == 3) begin
                chavePN = 1'($urandom);
                pontos  = 2'($urandom);
            end
            if (j == inj_at + 1) begin
                zerar = 1'b0;
                reset = 1'b0;
            end
            if (inj == 1 && j == inj_at) zerar = 1'b1;
            if (inj == 2 && j == inj_at) reset = 1'b1;
            if (j == hold) botao = 1'b0;
        end
        pontos = 2'd0;
    endtask

    vec_t tbl[20];
    int   na, nb, fi, ie, po;
    int   modelo;
    int   e_at, e_bl;
    logic r_sub;
    logic [1:0] r_pts;
    int   r_hold;

    initial begin
        tbl[0]  = '{1'b0, 2'd3, 5, 1, 3, 1, 0};
        tbl[1]  = '{1'b0, 2'd3, 5, 1, 6, 1, 0};
        tbl[2]  = '{1'b0, 2'd3, 5, 1, 9, 1, 0};
        tbl[3]  = '{1'b0, 2'd3, 5, 1, 12, 1, 0};
        tbl[4]  = '{1'b1, 2'd3, 3, 1, 9, 1, 0};
        tbl[5]  = '{1'b1, 2'd3, 3, 1, 6, 1, 0};
        tbl[6]  = '{1'b1, 2'd3, 3, 1, 3, 1, 0};
        tbl[7]  = '{1'b1, 2'd2, 3, 1, 1, 1, 0};
        tbl[8]  = '{1'b1, 2'd2, 3, 1, 1, 0, 1};
        tbl[9]  = '{1'b1, 2'd1, 3, 1, 0, 1, 0};
        tbl[10] = '{1'b1, 2'd1, 3, 1, 0, 0, 1};
        tbl[11] = '{1'b0, 2'd0, 3, 1, 0, 0, 0};
        tbl[12] = '{1'b1, 2'd0, 3, 1, 0, 0, 0};
        tbl[13] = '{1'b0, 2'd3, 2, 32, 96, 1, 0};
        tbl[14] = '{1'b0, 2'd2, 2, 1, 98, 1, 0};
        tbl[15] = '{1'b0, 2'd2, 2, 1, 98, 0, 1};
        tbl[16] = '{1'b0, 2'd3, 2, 1, 98, 0, 1};
        tbl[17] = '{1'b0, 2'd1, 2, 1, 99, 1, 0};
        tbl[18] = '{1'b0, 2'd1, 2, 1, 99, 0, 1};
        tbl[19] = '{1'b1, 2'd3, 1, 1, 96, 1, 0};

        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_score("reset", 0);
        chk("reset_at", int'(atualizado), 0);
        chk("reset_bl", int'(bloqueado), 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 20; i++) begin
            for (int r = 0; r < tbl[i].rep; r++)
                press(tbl[i].sub, tbl[i].pts, tbl[i].hold, 0, 0, na, nb, fi, ie, po);
            chk_score($sformatf("vec%0d", i), tbl[i].exp_placar);
            chk($sformatf("vec%0d_at", i), na, tbl[i].exp_at);
            chk($sformatf("vec%0d_bl", i), nb, tbl[i].exp_bl);
            if (tbl[i].exp_at + tbl[i].exp_bl > 0)
                chk($sformatf("vec%0d_lat", i), fi, LAT);
            chk($sformatf("vec%0d_inv", i), ie, 0);
        end

        // Standalone zerar clears the score.
        @(negedge clock); zerar = 1'b1;
        @(negedge clock); zerar = 1'b0;
        chk_score("zerar_idle", 0);
        repeat (3) @(negedge clock);

        // Build up to 10, then hold the button for 50 cycles: exactly one add.
        for (int i = 0; i < 3; i++) press(1'b0, 2'd3, 2, 0, 0, na, nb, fi, ie, po);
        press(1'b0, 2'd1, 2, 0, 0, na, nb, fi, ie, po);
        chk_score("build10", 10);
        press(1'b0, 2'd2, 50, 0, 0, na, nb, fi, ie, po);
        chk_score("hold50", 12);
        chk("hold50_at", na, 1);
        chk("hold50_bl", nb, 0);

        // zerar in the APLICA cycle discards the operation; held button stays inert.
        press(1'b0, 2'd3, 20, 1, 3, na, nb, fi, ie, po);
        chk("zap_post", po, 0);
        chk_score("zap_end", 0);
        chk("zap_at", na, 0);
        chk("zap_bl", nb, 0);
        press(1'b0, 2'd1, 3, 0, 0, na, nb, fi, ie, po);
        chk_score("zap_recover", 1);
        chk("zap_recover_at", na, 1);

        // Reset in the APLICA cycle; a still-held button must not apply.
        press(1'b0, 2'd2, 20, 2, 3, na, nb, fi, ie, po);
        chk("rst_post", po, 0);
        chk_score("rst_end", 0);
        chk("rst_at", na, 0);
        chk("rst_bl", nb, 0);
        press(1'b0, 2'd3, 3, 0, 0, na, nb, fi, ie, po);
        chk_score("rst_recover", 3);
        chk("rst_recover_lat", fi, LAT);

        // Randomized presses against a plain arithmetic model of the score.
        modelo = 3;
        for (int i = 0; i < 80; i++) begin
            r_sub  = ($urandom_range(9, 0) < 4) ? 1'b1 : 1'b0;
            r_pts  = 2'($urandom_range(3, 0));
            r_hold = $urandom_range(8, 1);
            e_at = 0; e_bl = 0;
            if (r_pts != 0) begin
                if (r_sub) begin
                    if (modelo < int'(r_pts)) e_bl = 1;
                    else begin modelo = modelo - int'(r_pts); e_at = 1; end
                end else begin
                    if (modelo + int'(r_pts) > 99) e_bl = 1;
                    else begin modelo = modelo + int'(r_pts); e_at = 1; end
                end
            end
            press(r_sub, r_pts, r_hold, 0, 0, na, nb, fi, ie, po);
            chk($sformatf("rnd%0d_placar", i), int'(placar), modelo);
            chk($sformatf("rnd%0d_pulses", i), na * 2 + nb, e_at * 2 + e_bl);
            chk($sformatf("rnd%0d_inv", i), ie, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acumulador_placar.md
Name: acumulador_placar

Overview:
- Score register stage for one team on the basketball scoreboard.
- Takes the operator's confirm button, the points selector (1/2/3) and the add/subtract switch chavePN. Performs one add or subtract per button press and holds the 7-bit score.
- The underflow guard is built in: a subtraction with score < pontos is rejected. An addition that would exceed PLACAR_MAX is also rejected.
- Drives the score in binary (to the comparison/validation logic) and in BCD tens/units (to the 7-segment decoders).

Parameters:
PLACAR_MAX, 99, highest legal score; must be ≤ 127.
SYNC_STAGES, 2, flip-flops in the botao synchronizer; minimum 2.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
botao  input  1  raw confirm push-button, asynchronous level, active-high
chavePN  input  1  0 = add, 1 = subtract
pontos  input  2  points to apply (1, 2, 3); 0 = no operation
zerar  input  1  synchronous score clear, active-high
placar  output  7  current score, binary
placar_dez  output  4  tens digit, BCD
placar_uni  output  4  units digit, BCD
atualizado  output  1  one-cycle pulse: score changed by an add/subtract
bloqueado  output  1  one-cycle pulse: operation rejected (underflow/overflow)

Behaviour:
- Reset (synchronous, active-high):
  - placar = 0, placar_dez = 0, placar_uni = 0.
  - atualizado = 0, bloqueado = 0.
  - Synchronizer and edge register = 0; FSM = OCIOSO.
  - Dominates all other inputs, including mid-operation.
- Synchronizer:
  - botao passes through SYNC_STAGES flops; the last stage is botao_s.
  - botao_s_d is a one-cycle-delayed copy; rising edge = botao_s & ~botao_s_d.
- FSM, states OCIOSO, APLICA, ESPERA_SOLTAR:
  - OCIOSO:
    - On rising edge of botao_s, capture pontos into op_pts and chavePN into op_sub.
    - If pontos == 0, go to ESPERA_SOLTAR (no pulse). Otherwise go to APLICA.
  - APLICA (exactly one cycle):
    - If op_sub = 1 and placar < op_pts: score unchanged, bloqueado = 1.
    - If op_sub = 0 and placar + op_pts > PLACAR_MAX: score unchanged, bloqueado = 1.
    - Otherwise placar ← placar ± op_pts and atualizado = 1.
    - Always go to ESPERA_SOLTAR.
  - ESPERA_SOLTAR: stay while botao_s = 1; go to OCIOSO when botao_s = 0.
  - Result: exactly one operation per press. Holding the button never repeats.
- Arithmetic:
  - Add in 8 bits so that the bound check against PLACAR_MAX cannot wrap.
  - Subtraction is only performed after the underflow check passes, so no wrap to 127 is possible.
- Latency and outputs:
  - botao first sampled high at edge k → new placar, atualizado/bloqueado valid after edge k + SYNC_STAGES + 1 (k+3 at default).
  - Operands are sampled at the OCIOSO→APLICA edge; changes to pontos/chavePN after that edge do not affect the press.
  - placar_dez/placar_uni are registered from the same next-score value as placar, so they update on the same edge. Invariant: placar == 10·dez + uni at every cycle.
  - atualizado and bloqueado are mutually exclusive, high for exactly one cycle, and 0 in every state other than APLICA.
- zerar (priority below reset, above the FSM):
  - Sets placar/dez/uni = 0 and the FSM to ESPERA_SOLTAR.
  - If it coincides with APLICA, the operation is discarded and neither pulse fires.
  - A press that is held during zerar does not apply after zerar releases; the button must be released first.
- A glitch shorter than one clock may or may not be captured. A single captured high still produces exactly one operation.

Test Plan:
- Reset, then press with chavePN=0, pontos=3 four times (each press held 5 cycles, released 5 cycles) → placar 3, 6, 9, 12; dez=1, uni=2; four atualizado pulses, each 3 cycles after the press edge.
- placar=1, chavePN=1, pontos=2 → bloqueado pulse, placar stays 1; then pontos=1 → placar=0, atualizado pulse.
- placar=98, add 2 → bloqueado, placar stays 98; add 1 → placar=99, dez=9, uni=9.
- Hold botao for 50 cycles with pontos=2 add from 10 → placar=12 exactly once; single atualizado.
- pontos=0 press → no pulses, placar unchanged. zerar asserted in the APLICA cycle → placar=0, no pulse, FSM waits for release.
- Reset asserted mid-press (state APLICA) → all outputs 0 the next cycle; a still-held button does not produce an operation until released and pressed again.
